// File: rtl/subtree_pkg.sv
// rtl/subtree_pkg.sv - shared types and defaults for subtree merge stages
package subtree_pkg;

    localparam int N_CHILD_DEFAULT = 5;
    localparam int DATA_W_DEFAULT  = 32;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [DATA_W_DEFAULT-1:0] data;
        logic                      last;
    } beat_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting at ptr
module rr_pick #(
    parameter  int N = 5,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] grant,
    output logic         any_req
);

    int idx;

    // Scan offsets from farthest to nearest so the closest requester wins.
    always_comb begin
        grant   = '0;
        any_req = |req;
        idx     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx]) grant = W'(idx);
        end
    end

endmodule

// File: rtl/subtree_merge_arbiter.sv
// rtl/subtree_merge_arbiter.sv - packet-granular round-robin merge of child streams
module subtree_merge_arbiter
    import subtree_pkg::*;
#(
    parameter  int N_CHILD = N_CHILD_DEFAULT,
    parameter  int DATA_W  = DATA_W_DEFAULT,
    localparam int SRC_W   = $clog2(N_CHILD)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CHILD-1:0]        in_valid,
    output logic [N_CHILD-1:0]        in_ready,
    input  logic [N_CHILD*DATA_W-1:0] in_data,
    input  logic [N_CHILD-1:0]        in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [SRC_W-1:0]          out_src,
    output logic                      out_last,
    output logic                      busy
);

    arb_state_e        state, state_nxt;
    logic [SRC_W-1:0]  rr_ptr, rr_ptr_nxt;
    logic [SRC_W-1:0]  owner, owner_nxt;
    logic [SRC_W-1:0]  grant;
    logic              any_req;
    logic [SRC_W-1:0]  sel_src;
    logic              sel_valid;
    logic              sel_last;
    logic [DATA_W-1:0] sel_data;
    logic              load_en;
    logic              accept;

    function automatic logic [SRC_W-1:0] inc_wrap(input logic [SRC_W-1:0] v);
        return (v == SRC_W'(N_CHILD - 1)) ? '0 : v + SRC_W'(1);
    endfunction

    rr_pick #(.N(N_CHILD)) u_pick (
        .req     (in_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .any_req (any_req)
    );

    assign load_en = out_ready | ~out_valid;
    assign busy    = (state == ARB_LOCKED);

    // Only the selected child's fields reach the output mux, so X on others is harmless.
    always_comb begin
        sel_src   = (state == ARB_LOCKED) ? owner : grant;
        sel_valid = (state == ARB_LOCKED) ? in_valid[sel_src] : any_req;
        sel_last  = in_last[sel_src];
        sel_data  = in_data[int'(sel_src)*DATA_W +: DATA_W];
        accept    = load_en & sel_valid;
        in_ready  = '0;
        if (state == ARB_LOCKED || any_req)
            in_ready[sel_src] = load_en;
    end

    always_comb begin
        state_nxt  = state;
        rr_ptr_nxt = rr_ptr;
        owner_nxt  = owner;
        case (state)
            ARB_IDLE: begin
                if (accept) begin
                    if (sel_last) begin
                        rr_ptr_nxt = inc_wrap(grant);
                    end else begin
                        state_nxt = ARB_LOCKED;
                        owner_nxt = grant;
                    end
                end
            end
            ARB_LOCKED: begin
                if (accept && sel_last) begin
                    state_nxt  = ARB_IDLE;
                    rr_ptr_nxt = inc_wrap(owner);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ARB_IDLE;
            rr_ptr <= '0;
            owner  <= '0;
        end else begin
            state  <= state_nxt;
            rr_ptr <= rr_ptr_nxt;
            owner  <= owner_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= accept;
            if (accept) begin
                out_data <= sel_data;
                out_src  <= sel_src;
                out_last <= sel_last;
            end
        end
    end

endmodule

// File: tb/tb_subtree_merge_arbiter.sv
// tb/tb_subtree_merge_arbiter.sv - directed self-checking bench for subtree_merge_arbiter
module tb_subtree_merge_arbiter;

    localparam int N = 5;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    in_valid;
    logic [N-1:0]    in_ready;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [2:0]      out_src;
    logic            out_last;
    logic            busy;

    int checks = 0;
    int failures = 0;

    subtree_merge_arbiter #(.N_CHILD(N), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_child(input int i, input logic [DW-1:0] d, input logic l);
        in_data[i*DW +: DW] = d;
        in_last[i] = l;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [2:0] s,
                           input logic [DW-1:0] d, input logic l);
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".src"}, out_src, s);
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".last"}, out_last, l);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = '0;
        in_data = 'x;
        in_last = 'x;
        out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk_out("reset", 1'b0, 3'd0, 32'h0, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.in_ready", in_ready, 5'h00);

        // all children valid, single-beat packets: strict rotation 0..4,0,1
        for (int i = 0; i < N; i++) set_child(i, 32'h10 + i, 1'b1);
        in_valid = 5'h1f;
        for (int k = 0; k < 7; k++) begin
            #1;
            chk("rot.in_ready", in_ready, 5'h01 << (k % 5));
            step();
            chk_out("rot.out", 1'b1, 3'(k % 5), 32'h10 + (k % 5), 1'b1);
        end
        in_valid = '0;
        in_data = 'x;
        in_last = 'x;
        step();
        chk("rot.drain_valid", out_valid, 1'b0);

        // rr_ptr=2: child 2 three-beat packet holds off child 3
        in_valid = 5'h0c;
        set_child(3, 32'h33, 1'b1);
        set_child(2, 32'hA0, 1'b0);
        #1;
        chk("lock.ready0", in_ready, 5'h04);
        step();
        chk_out("lock.b0", 1'b1, 3'd2, 32'hA0, 1'b0);
        chk("lock.busy0", busy, 1'b1);
        set_child(2, 32'hA1, 1'b0);
        #1;
        chk("lock.ready1", in_ready, 5'h04);
        step();
        chk_out("lock.b1", 1'b1, 3'd2, 32'hA1, 1'b0);
        chk("lock.busy1", busy, 1'b1);
        set_child(2, 32'hA2, 1'b1);
        step();
        chk_out("lock.b2", 1'b1, 3'd2, 32'hA2, 1'b1);
        chk("lock.busy2", busy, 1'b0);
        in_valid = 5'h08;
        #1;
        chk("lock.ready3", in_ready, 5'h08);
        step();
        chk_out("lock.c3", 1'b1, 3'd3, 32'h33, 1'b1);
        in_valid = '0;
        in_data = 'x;
        in_last = 'x;
        step();

        // rr_ptr=4: child 0 wins, then stall for 4 cycles
        in_valid = 5'h03;
        set_child(0, 32'h50, 1'b1);
        set_child(1, 32'h51, 1'b1);
        step();
        chk_out("stall.first", 1'b1, 3'd0, 32'h50, 1'b1);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("stall.in_ready", in_ready, 5'h00);
            step();
            chk_out("stall.hold", 1'b1, 3'd0, 32'h50, 1'b1);
            chk("stall.busy", busy, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("stall.release_ready", in_ready, 5'h02);
        step();
        chk_out("stall.next1", 1'b1, 3'd1, 32'h51, 1'b1);
        #1;
        chk("stall.release_ready2", in_ready, 5'h01);
        step();
        chk_out("stall.next0", 1'b1, 3'd0, 32'h50, 1'b1);
        in_valid = '0;
        in_data = 'x;
        in_last = 'x;
        step();
        chk("stall.idle_valid", out_valid, 1'b0);

        // rr_ptr=1: lock child 4, owner goes quiet for 2 cycles, child 0 must wait
        in_valid = 5'h11;
        set_child(4, 32'hC0, 1'b0);
        set_child(0, 32'h0D, 1'b1);
        #1;
        chk("bub.ready0", in_ready, 5'h10);
        step();
        chk_out("bub.c0", 1'b1, 3'd4, 32'hC0, 1'b0);
        in_valid = 5'h01;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk("bub.no_c0_ready", in_ready, 5'h10);
            step();
            chk("bub.valid", out_valid, 1'b0);
            chk("bub.busy", busy, 1'b1);
        end
        in_valid = 5'h11;
        set_child(4, 32'hC1, 1'b1);
        step();
        chk_out("bub.c1", 1'b1, 3'd4, 32'hC1, 1'b1);
        chk("bub.busy_end", busy, 1'b0);
        set_child(4, 32'hC2, 1'b1);
        #1;
        chk("bub.wrap_ready", in_ready, 5'h01);
        step();
        chk_out("bub.wrap", 1'b1, 3'd0, 32'h0D, 1'b1);
        in_valid = '0;
        in_data = 'x;
        in_last = 'x;
        step();

        // reset while locked with a beat in the output register
        in_valid = 5'h04;
        set_child(2, 32'hE0, 1'b0);
        step();
        chk_out("rst.pre", 1'b1, 3'd2, 32'hE0, 1'b0);
        chk("rst.pre_busy", busy, 1'b1);
        rst = 1'b1;
        step();
        chk("rst.valid", out_valid, 1'b0);
        chk("rst.busy", busy, 1'b0);
        chk("rst.src", out_src, 3'd0);
        rst = 1'b0;
        in_valid = 5'h05;
        set_child(0, 32'h0E, 1'b1);
        set_child(2, 32'hE1, 1'b1);
        #1;
        chk("rst.restart_ready", in_ready, 5'h01);
        step();
        chk_out("rst.restart", 1'b1, 3'd0, 32'h0E, 1'b1);
        in_valid = '0;
        in_data = 'x;
        in_last = 'x;
        step();

        // rr_ptr=1: only child 1 streams single-beat packets
        in_valid = 5'h02;
        for (int k = 0; k < 3; k++) begin
            set_child(1, 32'h100 + k, 1'b1);
            #1;
            chk("solo.ready", in_ready, 5'h02);
            step();
            chk_out("solo.out", 1'b1, 3'd1, 32'h100 + k, 1'b1);
        end
        in_valid = 5'h06;
        set_child(2, 32'h200, 1'b1);
        #1;
        chk("solo.ptr_after", in_ready, 5'h04);
        step();
        chk_out("solo.c2", 1'b1, 3'd2, 32'h200, 1'b1);
        in_valid = '0;
        step();
        chk("final.valid", out_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
